// File: rtl/display_8080_receiver_pkg.sv
// Shared definitions for the 8080 display receiver.
//   - Display command opcodes understood by the receiver.
//   - RGB565 -> RGBA4444 bit positions and the conversion helper.
package display_8080_receiver_pkg;

    // Command opcodes
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    // RGBA4444 takes the top four bits of each RGB565 channel
    localparam int         RGBA_R_MSB = 15;  // red   p[15:11] -> p[15:12]
    localparam int         RGBA_G_MSB = 10;  // green p[10:5]  -> p[10:7]
    localparam int         RGBA_B_MSB = 4;   // blue  p[4:0]   -> p[4:1]
    localparam logic [3:0] RGBA_ALPHA = 4'hF;

    function automatic logic [15:0] rgb565_to_rgba4444(input logic [15:0] p);
        return {p[RGBA_R_MSB -: 4], p[RGBA_G_MSB -: 4], p[RGBA_B_MSB -: 4], RGBA_ALPHA};
    endfunction

endpackage

// File: rtl/display_8080_bus_sync.sv
// Brings the asynchronous 8080 bus into the clk domain.
//   clk, resetn          : clock, asynchronous active-low reset
//   wr, cs, dc, data     : raw 8080 bus pins
//   strobe               : 1-cycle pulse on a synchronized wr rising edge with cs low
//   strobe_dc/strobe_data: dc and data from the same synchronizer stage as the edge
module display_8080_bus_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr,
    input  logic       cs,
    input  logic       dc,
    input  logic [7:0] data,
    output logic       strobe,
    output logic       strobe_dc,
    output logic [7:0] strobe_data
);

    // Bit layout of the synchronized vector: {wr, cs, dc, data}
    localparam int         W    = 11;
    localparam logic [W-1:0] IDLE = {1'b1, 1'b1, 1'b0, 8'h00};

    logic [W-1:0] async_vec;
    logic [W-1:0] sync_vec;
    logic         wr_prev_reg;

    assign async_vec = {wr, cs, dc, data};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    meta_reg <= IDLE[gi];
                    sync_reg <= IDLE[gi];
                end else begin
                    meta_reg <= async_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    // Delayed copy of synchronized wr for rising-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_prev_reg <= 1'b1;
        end else begin
            wr_prev_reg <= sync_vec[10];
        end
    end

    assign strobe      = sync_vec[10] & ~wr_prev_reg & ~sync_vec[9];
    assign strobe_dc   = sync_vec[8];
    assign strobe_data = sync_vec[7:0];

endmodule

// File: rtl/display_8080_receiver.sv
// 8080-bus display controller front end producing an AXI-Stream pixel stream.
//   aclk, resetn     : clock, asynchronous active-low reset
//   data, wr, cs, dc : 8080 write bus (asynchronous to aclk); rd is unused
//   m_axis_*         : single-register pixel stream, tlast marks window end
//   overflow         : sticky, set when a pixel arrives while the output is blocked
//   last_cmd         : most recent command byte
module display_8080_receiver
    import display_8080_receiver_pkg::*;
#(
    parameter int STREAM_COLORMODE_RGBA = 0,
    parameter int X_RES                 = 240,
    parameter int Y_RES                 = 320
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic [7:0]  data,
    input  logic        wr,
    input  logic        cs,
    input  logic        dc,
    input  logic        rd,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [7:0]  last_cmd
);

    localparam logic [15:0] X_DEF_END = 16'(X_RES - 1);
    localparam logic [15:0] Y_DEF_END = 16'(Y_RES - 1);

    logic       unused_rd;
    assign unused_rd = rd;

    logic       bus_strobe;
    logic       bus_dc;
    logic [7:0] bus_data;

    display_8080_bus_sync u_bus_sync (
        .clk        (aclk),
        .resetn     (resetn),
        .wr         (wr),
        .cs         (cs),
        .dc         (dc),
        .data       (data),
        .strobe     (bus_strobe),
        .strobe_dc  (bus_dc),
        .strobe_data(bus_data)
    );

    logic [7:0]  last_cmd_reg,  last_cmd_next;
    logic [2:0]  param_idx_reg, param_idx_next;
    logic        phase_high_reg, phase_high_next;
    logic [7:0]  hi_byte_reg,   hi_byte_next;
    logic [15:0] x_start_reg,   x_start_next;
    logic [15:0] x_end_reg,     x_end_next;
    logic [15:0] y_start_reg,   y_start_next;
    logic [15:0] y_end_reg,     y_end_next;
    logic [15:0] x_pos_reg,     x_pos_next;
    logic [15:0] y_pos_reg,     y_pos_next;
    logic        tvalid_reg,    tvalid_next;
    logic [15:0] tdata_reg,     tdata_next;
    logic        tlast_reg,     tlast_next;
    logic        overflow_reg,  overflow_next;

    logic [15:0] pixel_word;
    logic [15:0] pixel_out;
    logic        window_invalid;
    logic        at_end;

    assign pixel_word = {hi_byte_reg, bus_data};

    generate
        if (STREAM_COLORMODE_RGBA != 0) begin : g_rgba
            assign pixel_out = rgb565_to_rgba4444(pixel_word);
        end else begin : g_rgb565
            assign pixel_out = pixel_word;
        end
    endgenerate

    // An inverted window pins the position to its start and flags every pixel as last
    assign window_invalid = (x_end_reg < x_start_reg) || (y_end_reg < y_start_reg);
    assign at_end = window_invalid || ((x_pos_reg == x_end_reg) && (y_pos_reg == y_end_reg));

    always_comb begin
        last_cmd_next   = last_cmd_reg;
        param_idx_next  = param_idx_reg;
        phase_high_next = phase_high_reg;
        hi_byte_next    = hi_byte_reg;
        x_start_next    = x_start_reg;
        x_end_next      = x_end_reg;
        y_start_next    = y_start_reg;
        y_end_next      = y_end_reg;
        x_pos_next      = x_pos_reg;
        y_pos_next      = y_pos_reg;
        tvalid_next     = tvalid_reg;
        tdata_next      = tdata_reg;
        tlast_next      = tlast_reg;
        overflow_next   = overflow_reg;

        if (tvalid_reg && m_axis_tready) begin
            tvalid_next = 1'b0;
        end

        if (bus_strobe && !bus_dc) begin
            last_cmd_next   = bus_data;
            param_idx_next  = 3'd0;
            phase_high_next = 1'b1;
            if (bus_data == CMD_SWRESET) begin
                x_start_next = 16'd0;
                x_end_next   = X_DEF_END;
                y_start_next = 16'd0;
                y_end_next   = Y_DEF_END;
                x_pos_next   = 16'd0;
                y_pos_next   = 16'd0;
            end else if (bus_data == CMD_RAMWR) begin
                x_pos_next = x_start_reg;
                y_pos_next = y_start_reg;
            end
        end else if (bus_strobe) begin
            case (last_cmd_reg)
                CMD_CASET, CMD_PASET: begin
                    if (param_idx_reg < 3'd4) begin
                        param_idx_next = param_idx_reg + 3'd1;
                        if (last_cmd_reg == CMD_CASET) begin
                            case (param_idx_reg[1:0])
                                2'd0:    x_start_next[15:8] = bus_data;
                                2'd1:    x_start_next[7:0]  = bus_data;
                                2'd2:    x_end_next[15:8]   = bus_data;
                                default: x_end_next[7:0]    = bus_data;
                            endcase
                        end else begin
                            case (param_idx_reg[1:0])
                                2'd0:    y_start_next[15:8] = bus_data;
                                2'd1:    y_start_next[7:0]  = bus_data;
                                2'd2:    y_end_next[15:8]   = bus_data;
                                default: y_end_next[7:0]    = bus_data;
                            endcase
                        end
                    end
                end
                CMD_RAMWR, CMD_RAMWRC: begin
                    if (phase_high_reg) begin
                        hi_byte_next    = bus_data;
                        phase_high_next = 1'b0;
                    end else begin
                        phase_high_next = 1'b1;
                        // Completed pixel: load if the register frees this cycle, else drop
                        if (!tvalid_reg || m_axis_tready) begin
                            tvalid_next = 1'b1;
                            tdata_next  = pixel_out;
                            tlast_next  = at_end;
                            if (window_invalid) begin
                                x_pos_next = x_start_reg;
                                y_pos_next = y_start_reg;
                            end else if (x_pos_reg == x_end_reg) begin
                                x_pos_next = x_start_reg;
                                y_pos_next = (y_pos_reg == y_end_reg) ? y_start_reg
                                                                      : y_pos_reg + 16'd1;
                            end else begin
                                x_pos_next = x_pos_reg + 16'd1;
                            end
                        end else begin
                            overflow_next = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            last_cmd_reg   <= 8'h00;
            param_idx_reg  <= 3'd0;
            phase_high_reg <= 1'b1;
            hi_byte_reg    <= 8'h00;
            x_start_reg    <= 16'd0;
            x_end_reg      <= X_DEF_END;
            y_start_reg    <= 16'd0;
            y_end_reg      <= Y_DEF_END;
            x_pos_reg      <= 16'd0;
            y_pos_reg      <= 16'd0;
            tvalid_reg     <= 1'b0;
            tdata_reg      <= 16'd0;
            tlast_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            last_cmd_reg   <= last_cmd_next;
            param_idx_reg  <= param_idx_next;
            phase_high_reg <= phase_high_next;
            hi_byte_reg    <= hi_byte_next;
            x_start_reg    <= x_start_next;
            x_end_reg      <= x_end_next;
            y_start_reg    <= y_start_next;
            y_end_reg      <= y_end_next;
            x_pos_reg      <= x_pos_next;
            y_pos_reg      <= y_pos_next;
            tvalid_reg     <= tvalid_next;
            tdata_reg      <= tdata_next;
            tlast_reg      <= tlast_next;
            overflow_reg   <= overflow_next;
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tlast  = tlast_reg;
    assign overflow      = overflow_reg;
    assign last_cmd      = last_cmd_reg;

endmodule
